// File: rtl/load_scoreboard_if.sv
// ---------------------------------------------------------------------------------------------
// load_scoreboard_if
//   Bundles the decode-side request signals and the scoreboard's control/status outputs.
//   Signal directions are named from the scoreboard's point of view (i_ into it, o_ out of it).
//
//   Optional feature macro: SB_PERF_CNT_EN adds the three stall-cause performance counters.
//
//   Modports
//     slave  : the scoreboard (consumes i_*, drives o_*)
//     master : decode / test driver (drives i_*, consumes o_*)
//
//   Signals
//     i_flush, i_is_load, i_is_writeback, i_uses_rs1, i_uses_rs2 : decode qualifiers
//     i_rs1, i_rs2, i_rd                                         : decode register indices
//     i_ld_valid                                                 : oldest load returns data
//     o_ld_rd, o_wb_sel_ld, o_reg_we                             : shared write-port control
//     o_fetch_stall, o_ld_en, o_st_en                            : pipeline control
//     o_pending_cnt, o_sb_full, o_sb_empty, o_sb_err             : FIFO status
//     o_perf_haz_stalls, o_perf_cap_stalls, o_perf_port_stalls   : SB_PERF_CNT_EN only
// ---------------------------------------------------------------------------------------------
interface load_scoreboard_if #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
);
    localparam int unsigned PendW = $clog2(DEPTH + 1);

    logic                  i_flush;
    logic                  i_is_load;
    logic                  i_is_writeback;
    logic                  i_uses_rs1;
    logic                  i_uses_rs2;
    logic [REG_ADDR_W-1:0] i_rs1;
    logic [REG_ADDR_W-1:0] i_rs2;
    logic [REG_ADDR_W-1:0] i_rd;
    logic                  i_ld_valid;

    logic [REG_ADDR_W-1:0] o_ld_rd;
    logic                  o_wb_sel_ld;
    logic                  o_reg_we;
    logic                  o_fetch_stall;
    logic                  o_ld_en;
    logic                  o_st_en;
    logic [PendW-1:0]      o_pending_cnt;
    logic                  o_sb_full;
    logic                  o_sb_empty;
    logic                  o_sb_err;
`ifdef SB_PERF_CNT_EN
    logic [CNT_W-1:0]      o_perf_haz_stalls;
    logic [CNT_W-1:0]      o_perf_cap_stalls;
    logic [CNT_W-1:0]      o_perf_port_stalls;
`endif

    modport slave (
        input  i_flush, i_is_load, i_is_writeback, i_uses_rs1, i_uses_rs2,
        input  i_rs1, i_rs2, i_rd, i_ld_valid,
        output o_ld_rd, o_wb_sel_ld, o_reg_we, o_fetch_stall, o_ld_en, o_st_en,
        output o_pending_cnt, o_sb_full, o_sb_empty, o_sb_err
`ifdef SB_PERF_CNT_EN
        ,
        output o_perf_haz_stalls, o_perf_cap_stalls, o_perf_port_stalls
`endif
    );

    modport master (
        output i_flush, i_is_load, i_is_writeback, i_uses_rs1, i_uses_rs2,
        output i_rs1, i_rs2, i_rd, i_ld_valid,
        input  o_ld_rd, o_wb_sel_ld, o_reg_we, o_fetch_stall, o_ld_en, o_st_en,
        input  o_pending_cnt, o_sb_full, o_sb_empty, o_sb_err
`ifdef SB_PERF_CNT_EN
        ,
        input  o_perf_haz_stalls, o_perf_cap_stalls, o_perf_port_stalls
`endif
    );

endinterface

// File: rtl/load_scoreboard.sv
// ---------------------------------------------------------------------------------------------
// load_scoreboard
//   Hazard/control unit between decode and the regfile/LSU. Tracks up to DEPTH outstanding
//   loads (returned in order) in a tag FIFO and produces fetch stall, load/store issue enables
//   and write-port control (load return vs. ALU writeback).
//
//   Optional feature macro: SB_PERF_CNT_EN adds saturating stall-cause counters.
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     sb_if  : load_scoreboard_if.slave (decode inputs, control/status outputs)
// ---------------------------------------------------------------------------------------------
module load_scoreboard #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    load_scoreboard_if.slave        sb_if
);
    localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PendW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0]  LastPtr  = PtrW'(DEPTH - 1);
    localparam logic [PendW-1:0] FullCnt  = PendW'(DEPTH);

    if (DEPTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("load_scoreboard: DEPTH and CNT_W must be >= 1");
    end

    logic [REG_ADDR_W-1:0] r_tags [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [PtrW-1:0]       r_head;
    logic [PtrW-1:0]       r_tail;
    logic [PendW-1:0]      r_count;
    logic                  r_err;

    logic w_empty, w_full, w_pop, w_push;
    logic w_match_rs1, w_match_rs2, w_match_rd;
    logic w_raw_haz, w_waw_haz, w_data_haz, w_cap_blk, w_port_blk;
    logic w_stall, w_ld_en;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FullCnt);
    assign w_pop   = sb_if.i_ld_valid & ~w_empty;

    // The head entry still counts as valid in the cycle it pops: there is no load-data bypass.
    always_comb begin
        w_match_rs1 = 1'b0;
        w_match_rs2 = 1'b0;
        w_match_rd  = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (r_valid[i] && r_tags[i] == sb_if.i_rs1) w_match_rs1 = 1'b1;
            if (r_valid[i] && r_tags[i] == sb_if.i_rs2) w_match_rs2 = 1'b1;
            if (r_valid[i] && r_tags[i] == sb_if.i_rd)  w_match_rd  = 1'b1;
        end
        // x0 never carries a dependency.
        if (sb_if.i_rs1 == '0) w_match_rs1 = 1'b0;
        if (sb_if.i_rs2 == '0) w_match_rs2 = 1'b0;
        if (sb_if.i_rd == '0)  w_match_rd  = 1'b0;
    end

    assign w_raw_haz  = (sb_if.i_uses_rs1 & w_match_rs1) | (sb_if.i_uses_rs2 & w_match_rs2);
    assign w_waw_haz  = sb_if.i_is_writeback & w_match_rd;
    assign w_data_haz = w_raw_haz | w_waw_haz;
    // A same-cycle pop frees a slot for the incoming load.
    assign w_cap_blk  = sb_if.i_is_load & w_full & ~w_pop;
    // A returning load owns the single write port; the ALU instruction retries.
    assign w_port_blk = w_pop & sb_if.i_is_writeback;
    assign w_stall    = ~sb_if.i_flush & (w_data_haz | w_cap_blk | w_port_blk);
    assign w_ld_en    = ~sb_if.i_flush & ~w_data_haz & ~w_cap_blk;
    // rd==0 loads are still tracked so returns stay in order.
    assign w_push     = sb_if.i_is_load & w_ld_en & ~w_stall;

    assign sb_if.o_fetch_stall = w_stall;
    assign sb_if.o_ld_en       = w_ld_en;
    assign sb_if.o_st_en       = ~sb_if.i_flush & ~w_data_haz;
    assign sb_if.o_wb_sel_ld   = w_pop;
    // Load returns write even under flush: they are older than the squashed instruction.
    assign sb_if.o_reg_we      = w_pop | (~sb_if.i_flush & sb_if.i_is_writeback & ~w_stall);
    assign sb_if.o_ld_rd       = r_tags[r_head];
    assign sb_if.o_pending_cnt = r_count;
    assign sb_if.o_sb_full     = w_full;
    assign sb_if.o_sb_empty    = w_empty;
    assign sb_if.o_sb_err      = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) r_tags[i] <= '0;
            r_valid <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (sb_if.i_ld_valid && w_empty) r_err <= 1'b1;
            // Clear before set: when full with push & pop, head == tail and the new entry wins.
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= (r_head == LastPtr) ? '0 : r_head + 1'b1;
            end
            if (w_push) begin
                r_tags[r_tail]  <= sb_if.i_rd;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= (r_tail == LastPtr) ? '0 : r_tail + 1'b1;
            end
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

`ifdef SB_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_haz, r_perf_cap, r_perf_port;

    // Several causes can be counted in the same stalled cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_haz  <= '0;
            r_perf_cap  <= '0;
            r_perf_port <= '0;
        end else if (!sb_if.i_flush) begin
            if (w_data_haz && r_perf_haz != '1)  r_perf_haz  <= r_perf_haz + 1'b1;
            if (w_cap_blk && r_perf_cap != '1)   r_perf_cap  <= r_perf_cap + 1'b1;
            if (w_port_blk && r_perf_port != '1) r_perf_port <= r_perf_port + 1'b1;
        end
    end

    assign sb_if.o_perf_haz_stalls  = r_perf_haz;
    assign sb_if.o_perf_cap_stalls  = r_perf_cap;
    assign sb_if.o_perf_port_stalls = r_perf_port;
`endif

endmodule

// File: tb/tb_load_scoreboard.sv
module tb_load_scoreboard;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    load_scoreboard_if #(.DEPTH(4), .REG_ADDR_W(5), .CNT_W(32)) sb_if ();

    load_scoreboard #(.DEPTH(4), .REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb_if (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic flush, input logic is_load, input logic is_wb,
                         input logic u1, input logic u2, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic ld_valid);
        sb_if.i_flush        = flush;
        sb_if.i_is_load      = is_load;
        sb_if.i_is_writeback = is_wb;
        sb_if.i_uses_rs1     = u1;
        sb_if.i_uses_rs2     = u2;
        sb_if.i_rs1          = rs1;
        sb_if.i_rs2          = rs2;
        sb_if.i_rd           = rd;
        sb_if.i_ld_valid     = ld_valid;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_tag [10];
        tests = 0;
        fails = 0;
        exp_tag[0] = 5'd1;  exp_tag[1] = 5'd2;  exp_tag[2] = 5'd3;  exp_tag[3] = 5'd4;
        exp_tag[4] = 5'd9;  exp_tag[5] = 5'd10; exp_tag[6] = 5'd11; exp_tag[7] = 5'd12;
        exp_tag[8] = 5'd13; exp_tag[9] = 5'd14;

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_pending", 32'(sb_if.o_pending_cnt), 0);
        chk("rst_empty", 32'(sb_if.o_sb_empty), 1);
        chk("rst_full", 32'(sb_if.o_sb_full), 0);
        chk("rst_err", 32'(sb_if.o_sb_err), 0);
        chk("rst_stall", 32'(sb_if.o_fetch_stall), 0);
        #9;
        rst_n = 1'b1;
        cyc();

        // 1: ld_valid while empty
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t1_reg_we", 32'(sb_if.o_reg_we), 0);
        chk("t1_wb_sel", 32'(sb_if.o_wb_sel_ld), 0);
        cyc();
        chk("t1_err_set", 32'(sb_if.o_sb_err), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("t1_err_sticky", 32'(sb_if.o_sb_err), 1);
        chk("t1_still_empty", 32'(sb_if.o_sb_empty), 1);

        // 2: RAW on a pending load
        drive(0, 1, 0, 0, 0, 0, 0, 5, 0);
        chk("t2_ld_en", 32'(sb_if.o_ld_en), 1);
        chk("t2_push_nostall", 32'(sb_if.o_fetch_stall), 0);
        cyc();
        chk("t2_pending1", 32'(sb_if.o_pending_cnt), 1);
        drive(0, 0, 0, 1, 0, 5, 0, 0, 0);
        chk("t2_raw_stall", 32'(sb_if.o_fetch_stall), 1);
        chk("t2_raw_st_en", 32'(sb_if.o_st_en), 0);
        cyc();
        chk("t2_raw_stall2", 32'(sb_if.o_fetch_stall), 1);
        drive(0, 0, 0, 1, 0, 5, 0, 0, 1);
        chk("t2_pop_stall", 32'(sb_if.o_fetch_stall), 1);
        chk("t2_pop_we", 32'(sb_if.o_reg_we), 1);
        chk("t2_pop_sel", 32'(sb_if.o_wb_sel_ld), 1);
        chk("t2_pop_rd", 32'(sb_if.o_ld_rd), 5);
        cyc();
        drive(0, 0, 0, 1, 0, 5, 0, 0, 0);
        chk("t2_released", 32'(sb_if.o_fetch_stall), 0);
        chk("t2_empty", 32'(sb_if.o_sb_empty), 1);
        chk("t2_no_we", 32'(sb_if.o_reg_we), 0);

        // 3: capacity and wrap-around
        for (int i = 1; i <= 4; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0, 5'(i), 0);
            chk("t3_fill_ld_en", 32'(sb_if.o_ld_en), 1);
            cyc();
        end
        chk("t3_full", 32'(sb_if.o_sb_full), 1);
        chk("t3_pending4", 32'(sb_if.o_pending_cnt), 4);
        drive(0, 1, 0, 0, 0, 0, 0, 9, 0);
        chk("t3_cap_stall", 32'(sb_if.o_fetch_stall), 1);
        chk("t3_cap_ld_en", 32'(sb_if.o_ld_en), 0);
        chk("t3_cap_st_en", 32'(sb_if.o_st_en), 1);
        cyc();
        chk("t3_cap_no_push", 32'(sb_if.o_pending_cnt), 4);
        for (int k = 0; k < 6; k++) begin
            // first iteration pushes rd=9, then rd=10..14
            drive(0, 1, 0, 0, 0, 0, 0, (k == 0) ? 5'd9 : 5'(9 + k), 1);
            chk("t3_pp_stall", 32'(sb_if.o_fetch_stall), 0);
            chk("t3_pp_rd", 32'(sb_if.o_ld_rd), 32'(exp_tag[k]));
            chk("t3_pp_we", 32'(sb_if.o_reg_we), 1);
            cyc();
            chk("t3_pp_count", 32'(sb_if.o_pending_cnt), 4);
        end
        for (int k = 6; k < 10; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
            chk("t3_drain_rd", 32'(sb_if.o_ld_rd), 32'(exp_tag[k]));
            cyc();
        end
        chk("t3_drained", 32'(sb_if.o_sb_empty), 1);

        // 4: WAW and x0
        drive(0, 1, 0, 0, 0, 0, 0, 7, 0);
        cyc();
        drive(0, 0, 1, 0, 0, 0, 0, 7, 0);
        chk("t4_waw_stall", 32'(sb_if.o_fetch_stall), 1);
        chk("t4_waw_we", 32'(sb_if.o_reg_we), 0);
        drive(0, 0, 1, 0, 0, 0, 0, 3, 0);
        chk("t4_nowaw_stall", 32'(sb_if.o_fetch_stall), 0);
        chk("t4_nowaw_we", 32'(sb_if.o_reg_we), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_pop7", 32'(sb_if.o_ld_rd), 7);
        cyc();
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("t4_x0_ld_en", 32'(sb_if.o_ld_en), 1);
        cyc();
        chk("t4_x0_pushed", 32'(sb_if.o_pending_cnt), 1);
        drive(0, 0, 1, 1, 1, 0, 0, 0, 0);
        chk("t4_x0_nostall", 32'(sb_if.o_fetch_stall), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_pop_x0", 32'(sb_if.o_ld_rd), 0);
        cyc();

        // 5: load return and ALU writeback collide on the write port
        drive(0, 1, 0, 0, 0, 0, 0, 6, 0);
        cyc();
        drive(0, 0, 1, 0, 0, 0, 0, 8, 1);
        chk("t5_sel", 32'(sb_if.o_wb_sel_ld), 1);
        chk("t5_stall", 32'(sb_if.o_fetch_stall), 1);
        chk("t5_we", 32'(sb_if.o_reg_we), 1);
        chk("t5_rd", 32'(sb_if.o_ld_rd), 6);
        cyc();
        drive(0, 0, 1, 0, 0, 0, 0, 8, 0);
        chk("t5_alu_stall", 32'(sb_if.o_fetch_stall), 0);
        chk("t5_alu_we", 32'(sb_if.o_reg_we), 1);
        chk("t5_alu_sel", 32'(sb_if.o_wb_sel_ld), 0);
        cyc();

        // 6: flush dominates stalls, load return still writes
        drive(0, 1, 0, 0, 0, 0, 0, 4, 0);
        cyc();
        drive(1, 1, 0, 1, 0, 4, 0, 4, 1);
        chk("t6_stall", 32'(sb_if.o_fetch_stall), 0);
        chk("t6_ld_en", 32'(sb_if.o_ld_en), 0);
        chk("t6_st_en", 32'(sb_if.o_st_en), 0);
        chk("t6_we", 32'(sb_if.o_reg_we), 1);
        chk("t6_sel", 32'(sb_if.o_wb_sel_ld), 1);
        cyc();
        chk("t6_no_push", 32'(sb_if.o_pending_cnt), 0);
        chk("t6_err_kept", 32'(sb_if.o_sb_err), 1);

        // Reset mid-operation drops loads; a later return flags an error
        drive(0, 1, 0, 0, 0, 0, 0, 2, 0);
        cyc();
        chk("rst2_pending_pre", 32'(sb_if.o_pending_cnt), 1);
        rst_n = 1'b0;
        #1;
        chk("rst2_err_clr", 32'(sb_if.o_sb_err), 0);
        chk("rst2_empty", 32'(sb_if.o_sb_empty), 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        rst_n = 1'b1;
        chk("rst2_no_we", 32'(sb_if.o_reg_we), 0);
        cyc();
        chk("rst2_err_set", 32'(sb_if.o_sb_err), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
